// File: rtl/alarm_clock.sv
// =============================================================================
// alarm_clock
// -----------------------------------------------------------------------------
// Purpose:
//    24-hour digital alarm clock. A keypad entry buffer, a BCD time-of-day
//    counter, an alarm register with its comparator, and four registered ASCII
//    digit outputs showing HH:MM. The alarm flag rings when the running clock
//    reaches the armed alarm time. fast_watch compresses time so that one
//    minute passes per one-second tick.
//
// Parameters:
//    CLK_PER_SEC  clock cycles per one-second tick
//    KEY_TMO_SEC  second ticks without an accepted digit before entry aborts
//
// Ports:
//    clock         in   1  system clock, all state changes on the rising edge
//    reset         in   1  asynchronous, active-high; clears all state
//    fast_watch    in   1  1: minute counter advances on every second tick
//    alarm_button  in   1  pulse: load entry buffer into alarm / silence alarm
//    time_button   in   1  pulse: load entry buffer into current time
//    key           in   4  0-9 digit held; 10..15 means no key
//    alarm_sound   out  1  high while the alarm is ringing
//    ms_hour       out  8  ASCII tens-of-hours digit
//    ls_hour       out  8  ASCII units-of-hours digit
//    ms_minute     out  8  ASCII tens-of-minutes digit
//    ls_minute     out  8  ASCII units-of-minutes digit
//
// Configuration macro:
//    ALARM_AUTO_OFF_EN  when defined, a ringing alarm silences itself after
//                       60 second ticks unless alarm_button silences it
//                       first. When undefined, it rings until alarm_button
//                       or reset.
// =============================================================================
module alarm_clock #(
   parameter int CLK_PER_SEC = 256,
   parameter int KEY_TMO_SEC = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       fast_watch,
   input  logic       alarm_button,
   input  logic       time_button,
   input  logic [3:0] key,
   output logic       alarm_sound,
   output logic [7:0] ms_hour,
   output logic [7:0] ls_hour,
   output logic [7:0] ms_minute,
   output logic [7:0] ls_minute
);

   localparam int TW  = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam int TMW = (KEY_TMO_SEC > 1) ? $clog2(KEY_TMO_SEC) : 1;

   typedef enum logic {
      SHOW_TIME = 1'b0,
      KEY_ENTRY = 1'b1
   } state_t;

   state_t        state_q;

   logic [TW-1:0] tickCnt_q;
   logic          secTick;
   logic [5:0]    secCnt_q;
   logic          minuteAdvance;
   logic          minuteStep_q;

   logic          keyHeld_q;
   logic [3:0]    keyDigit_q;
   logic          keyIsDigit;
   logic          digitAccept;

   logic [3:0]    entry_q [4];
   logic [TMW-1:0] tmo_q;
   logic          entryValid;

   logic [1:0]    hrHi_q;
   logic [3:0]    hrLo_q;
   logic [2:0]    minHi_q;
   logic [3:0]    minLo_q;
   logic [1:0]    hrHi_d;
   logic [3:0]    hrLo_d;
   logic [2:0]    minHi_d;
   logic [3:0]    minLo_d;

   logic [1:0]    alarmHrHi_q;
   logic [3:0]    alarmHrLo_q;
   logic [2:0]    alarmMinHi_q;
   logic [3:0]    alarmMinLo_q;
   logic          armed_q;
   logic          sound_q;
   logic          timeMatch;
   logic          ringSet;
   logic          silence;
   logic          loadTime;
   logic          loadAlarm;

`ifdef ALARM_AUTO_OFF_EN
   logic [5:0]    ringCnt_q;
`endif

   logic [7:0]    dispMsHour_q;
   logic [7:0]    dispLsHour_q;
   logic [7:0]    dispMsMin_q;
   logic [7:0]    dispLsMin_q;

   // The one-second tick is a single-cycle pulse on the last count of the
   // prescaler, so everything that counts seconds sees exactly one pulse per
   // CLK_PER_SEC cycles regardless of what the rest of the design is doing.
   assign secTick = (tickCnt_q == TW'(CLK_PER_SEC - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tickCnt_q <= '0;
      end else if (secTick) begin
         tickCnt_q <= '0;
      end else begin
         tickCnt_q <= tickCnt_q + TW'(1);
      end
   end

   // In normal mode a minute passes on the tick that wraps the seconds
   // counter; in fast_watch mode every tick is a minute.
   assign minuteAdvance = secTick && (fast_watch || (secCnt_q == 6'd59));

   // A digit is taken on the release edge: the cycle after a digit was held
   // and the key now reads no-key. The latest held digit is remembered, so a
   // long press still yields exactly one digit when it is let go.
   assign keyIsDigit  = (key <= 4'd9);
   assign digitAccept = keyHeld_q && !keyIsDigit;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         keyHeld_q  <= 1'b0;
         keyDigit_q <= 4'd0;
      end else begin
         keyHeld_q <= keyIsDigit;
         if (keyIsDigit) begin
            keyDigit_q <= key;
         end
      end
   end

   // The buffer is only a legal time of day if HH <= 23 and MM <= 59. The
   // units digits are always 0-9 because only keypad digits reach the buffer.
   assign entryValid = ((entry_q[0] <= 4'd1) ||
                        ((entry_q[0] == 4'd2) && (entry_q[1] <= 4'd3))) &&
                       (entry_q[2] <= 4'd5);

   // Button decoding. time_button has priority, so whenever it is pressed the
   // alarm button is ignored completely. An alarm_button press while ringing
   // only silences; it never reloads the alarm register.
   assign silence   = alarm_button && !time_button && sound_q;
   assign loadTime  = (state_q == KEY_ENTRY) && time_button && entryValid;
   assign loadAlarm = (state_q == KEY_ENTRY) && !time_button && alarm_button &&
                      !sound_q && entryValid;

   // Next value of the BCD time when one minute passes, including the
   // 59 -> 00 minute carry and the 23:59 -> 00:00 day wrap.
   always_comb begin
      minLo_d = minLo_q + 4'd1;
      minHi_d = minHi_q;
      hrLo_d  = hrLo_q;
      hrHi_d  = hrHi_q;
      if (minLo_q == 4'd9) begin
         minLo_d = 4'd0;
         if (minHi_q == 3'd5) begin
            minHi_d = 3'd0;
            if ((hrHi_q == 2'd2) && (hrLo_q == 4'd3)) begin
               hrHi_d = 2'd0;
               hrLo_d = 4'd0;
            end else if (hrLo_q == 4'd9) begin
               hrLo_d = 4'd0;
               hrHi_d = hrHi_q + 2'd1;
            end else begin
               hrLo_d = hrLo_q + 4'd1;
            end
         end else begin
            minHi_d = minHi_q + 3'd1;
         end
      end
   end

   // Entry state machine. Entering KEY_ENTRY clears the buffer and then
   // shifts the first digit in, so one keystroke shows as 00:0d. Either
   // button leaves entry; the loads themselves are handled by the time and
   // alarm registers. With no digit for KEY_TMO_SEC ticks the entry aborts.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= SHOW_TIME;
         entry_q <= '{default: 4'd0};
         tmo_q   <= '0;
      end else if (state_q == SHOW_TIME) begin
         if (digitAccept) begin
            state_q    <= KEY_ENTRY;
            entry_q[0] <= 4'd0;
            entry_q[1] <= 4'd0;
            entry_q[2] <= 4'd0;
            entry_q[3] <= keyDigit_q;
            tmo_q      <= '0;
         end
      end else begin
         if (time_button || alarm_button) begin
            state_q <= SHOW_TIME;
         end else if (digitAccept) begin
            entry_q[0] <= entry_q[1];
            entry_q[1] <= entry_q[2];
            entry_q[2] <= entry_q[3];
            entry_q[3] <= keyDigit_q;
            tmo_q      <= '0;
         end else if (secTick) begin
            if (tmo_q == TMW'(KEY_TMO_SEC - 1)) begin
               state_q <= SHOW_TIME;
            end else begin
               tmo_q <= tmo_q + TMW'(1);
            end
         end
      end
   end

   // Current time and seconds. A load from the buffer overrides a minute
   // advance in the same cycle and restarts the seconds count. minuteStep_q
   // remembers that the clock itself moved last cycle, which is the only
   // moment the alarm comparator is allowed to fire.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hrHi_q       <= 2'd0;
         hrLo_q       <= 4'd0;
         minHi_q      <= 3'd0;
         minLo_q      <= 4'd0;
         secCnt_q     <= 6'd0;
         minuteStep_q <= 1'b0;
      end else if (loadTime) begin
         hrHi_q       <= entry_q[0][1:0];
         hrLo_q       <= entry_q[1];
         minHi_q      <= entry_q[2][2:0];
         minLo_q      <= entry_q[3];
         secCnt_q     <= 6'd0;
         minuteStep_q <= 1'b0;
      end else begin
         if (secTick) begin
            secCnt_q <= (secCnt_q == 6'd59) ? 6'd0 : secCnt_q + 6'd1;
         end
         if (minuteAdvance) begin
            hrHi_q  <= hrHi_d;
            hrLo_q  <= hrLo_d;
            minHi_q <= minHi_d;
            minLo_q <= minLo_d;
         end
         minuteStep_q <= minuteAdvance;
      end
   end

   // Alarm register. A valid buffer loaded with alarm_button arms the alarm;
   // it stays armed until reset, so it rings again each day.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         alarmHrHi_q  <= 2'd0;
         alarmHrLo_q  <= 4'd0;
         alarmMinHi_q <= 3'd0;
         alarmMinLo_q <= 4'd0;
         armed_q      <= 1'b0;
      end else if (loadAlarm) begin
         alarmHrHi_q  <= entry_q[0][1:0];
         alarmHrLo_q  <= entry_q[1];
         alarmMinHi_q <= entry_q[2][2:0];
         alarmMinLo_q <= entry_q[3];
         armed_q      <= 1'b1;
      end
   end

   assign timeMatch = (hrHi_q == alarmHrHi_q) && (hrLo_q == alarmHrLo_q) &&
                      (minHi_q == alarmMinHi_q) && (minLo_q == alarmMinLo_q);

   // Ring only when the running clock has just stepped onto the alarm time,
   // so loading the time or arming an alarm equal to the current time does
   // not ring by itself.
   assign ringSet = minuteStep_q && armed_q && timeMatch;

   // Alarm sound flag. Silencing beats a new ring request in the same cycle.
   // With the auto-off option a second counter runs while ringing and drops
   // the flag on the sixtieth tick.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sound_q   <= 1'b0;
`ifdef ALARM_AUTO_OFF_EN
         ringCnt_q <= 6'd0;
`endif
      end else if (silence) begin
         sound_q <= 1'b0;
      end else if (ringSet) begin
         sound_q   <= 1'b1;
`ifdef ALARM_AUTO_OFF_EN
         ringCnt_q <= 6'd0;
      end else if (sound_q && secTick) begin
         if (ringCnt_q == 6'd59) begin
            sound_q <= 1'b0;
         end else begin
            ringCnt_q <= ringCnt_q + 6'd1;
         end
`endif
      end
   end

   // Display registers: the buffer while entering digits, the running time
   // otherwise, each digit offset into ASCII '0'..'9'.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dispMsHour_q <= 8'h30;
         dispLsHour_q <= 8'h30;
         dispMsMin_q  <= 8'h30;
         dispLsMin_q  <= 8'h30;
      end else if (state_q == KEY_ENTRY) begin
         dispMsHour_q <= 8'h30 + {4'd0, entry_q[0]};
         dispLsHour_q <= 8'h30 + {4'd0, entry_q[1]};
         dispMsMin_q  <= 8'h30 + {4'd0, entry_q[2]};
         dispLsMin_q  <= 8'h30 + {4'd0, entry_q[3]};
      end else begin
         dispMsHour_q <= 8'h30 + {6'd0, hrHi_q};
         dispLsHour_q <= 8'h30 + {4'd0, hrLo_q};
         dispMsMin_q  <= 8'h30 + {5'd0, minHi_q};
         dispLsMin_q  <= 8'h30 + {4'd0, minLo_q};
      end
   end

   assign alarm_sound = sound_q;
   assign ms_hour     = dispMsHour_q;
   assign ls_hour     = dispLsHour_q;
   assign ms_minute   = dispMsMin_q;
   assign ls_minute   = dispLsMin_q;

endmodule

// File: tb/tb_alarm_clock.sv
// =============================================================================
// tb_alarm_clock
// -----------------------------------------------------------------------------
// Scoreboard bench for alarm_clock. The stimulus process drives the inputs,
// steps a behavioural model (time kept as minutes of the day, the entry
// buffer as an array of digits) and queues the expected display and alarm
// flag for every clock edge. An independent monitor pops the queue on each
// falling edge and compares against the DUT outputs.
// =============================================================================
module tb_alarm_clock;

   localparam int CPS = 256;
   localparam int TMO = 10;

   logic       clock;
   logic       reset;
   logic       fast_watch;
   logic       alarm_button;
   logic       time_button;
   logic [3:0] key;
   logic       alarm_sound;
   logic [7:0] ms_hour;
   logic [7:0] ls_hour;
   logic [7:0] ms_minute;
   logic [7:0] ls_minute;

   alarm_clock #(
      .CLK_PER_SEC (CPS),
      .KEY_TMO_SEC (TMO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .fast_watch   (fast_watch),
      .alarm_button (alarm_button),
      .time_button  (time_button),
      .key          (key),
      .alarm_sound  (alarm_sound),
      .ms_hour      (ms_hour),
      .ls_hour      (ls_hour),
      .ms_minute    (ms_minute),
      .ls_minute    (ls_minute)
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct packed {
      int          edgeNo;
      logic [31:0] disp;
      logic        snd;
   } expect_t;

   expect_t expQ[$];
   string   tagQ[$];
   int      edgeCount  = 0;
   int      checkCount = 0;
   int      errorCount = 0;
   string   phase      = "reset";

   // Reference model state: time and alarm as minutes of the day.
   int          mTime;
   int          mSec;
   int          mTick;
   int          mAlarm;
   int          mTmo;
   int          mKeyDigit;
   int          mRingSec;
   bit          mArmed;
   bit          mSound;
   bit          mEntry;
   bit          mKeyHeld;
   bit          mJustAdv;
   int          mBuf[4];
   logic [31:0] mDisp;

   function automatic logic [31:0] asciiOf(int a, int b, int c, int d);
      logic [7:0] v0, v1, v2, v3;
      v0 = 8'(48 + a);
      v1 = 8'(48 + b);
      v2 = 8'(48 + c);
      v3 = 8'(48 + d);
      return {v0, v1, v2, v3};
   endfunction

   function automatic logic [31:0] modelView();
      if (mEntry) return asciiOf(mBuf[0], mBuf[1], mBuf[2], mBuf[3]);
      return asciiOf((mTime / 60) / 10, (mTime / 60) % 10, (mTime % 60) / 10, (mTime % 60) % 10);
   endfunction

   function automatic void modelReset();
      mTime = 0; mSec = 0; mTick = 0; mAlarm = 0; mTmo = 0;
      mKeyDigit = 0; mRingSec = 0; mArmed = 0; mSound = 0; mEntry = 0;
      mKeyHeld = 0; mJustAdv = 0;
      mBuf  = '{0, 0, 0, 0};
      mDisp = 32'h30303030;
   endfunction

   // One rising clock edge of the reference behaviour, using the inputs as
   // they are held across that edge.
   function automatic void modelStep();
      logic [31:0] view;
      bit tick, accept, advance, valid, silence, ringSet, loadT, loadA;
      int k, bufTime;
      edgeCount++;
      if (reset) begin
         modelReset();
         return;
      end
      view    = modelView();
      k       = int'(key);
      tick    = (mTick == CPS - 1);
      accept  = mKeyHeld && (k >= 10);
      advance = tick && (fast_watch || mSec == 59);
      bufTime = (mBuf[0] * 10 + mBuf[1]) * 60 + mBuf[2] * 10 + mBuf[3];
      valid   = ((mBuf[0] * 10 + mBuf[1]) <= 23) && ((mBuf[2] * 10 + mBuf[3]) <= 59);
      silence = alarm_button && !time_button && mSound;
      ringSet = mJustAdv && mArmed && (mTime == mAlarm);
      loadT   = mEntry && time_button && valid;
      loadA   = mEntry && !time_button && alarm_button && !mSound && valid;

      if (silence) mSound = 0;
      else if (ringSet) begin
         mSound   = 1;
         mRingSec = 0;
      end
`ifdef ALARM_AUTO_OFF_EN
      else if (mSound && tick) begin
         mRingSec++;
         if (mRingSec == 60) mSound = 0;
      end
`endif

      if (loadA) begin
         mAlarm = bufTime;
         mArmed = 1;
      end

      if (loadT) begin
         mTime    = bufTime;
         mSec     = 0;
         mJustAdv = 0;
      end else begin
         if (tick) mSec = (mSec + 1) % 60;
         if (advance) mTime = (mTime + 1) % 1440;
         mJustAdv = advance;
      end

      if (!mEntry) begin
         if (accept) begin
            mEntry = 1;
            mBuf   = '{0, 0, 0, mKeyDigit};
            mTmo   = 0;
         end
      end else if (time_button || alarm_button) begin
         mEntry = 0;
      end else if (accept) begin
         mBuf = '{mBuf[1], mBuf[2], mBuf[3], mKeyDigit};
         mTmo = 0;
      end else if (tick) begin
         mTmo++;
         if (mTmo == TMO) mEntry = 0;
      end

      if (k <= 9) begin
         mKeyHeld  = 1;
         mKeyDigit = k;
      end else begin
         mKeyHeld = 0;
      end

      mTick = (mTick + 1) % CPS;
      mDisp = view;
   endfunction

   function automatic void pushExpect();
      expect_t e;
      e.edgeNo = edgeCount;
      e.disp   = mDisp;
      e.snd    = mSound;
      expQ.push_back(e);
      tagQ.push_back(phase);
   endfunction

   // Advance n clock edges, stepping the model and queueing an expectation
   // for each edge.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         modelStep();
         pushExpect();
      end
   endtask

   task automatic pressKey(input int d, input int hold);
      key = 4'(d);
      applyStimulus(hold);
      key = 4'($urandom_range(10, 15));
      applyStimulus(1);
   endtask

   task automatic enterTime(input int t, input int hold);
      pressKey((t / 60) / 10, hold);
      pressKey((t / 60) % 10, hold);
      pressKey((t % 60) / 10, hold);
      pressKey((t % 60) % 10, hold);
   endtask

   task automatic pulseTime();
      time_button = 1'b1;
      applyStimulus(1);
      time_button = 1'b0;
   endtask

   task automatic pulseAlarm();
      alarm_button = 1'b1;
      applyStimulus(1);
      alarm_button = 1'b0;
   endtask

   // Short reset pulse placed between rising edges, so only an asynchronous
   // clear can take effect.
   task automatic pulseReset();
      @(negedge clock);
      #1;
      reset = 1'b1;
      modelReset();
      #2;
      reset = 1'b0;
   endtask

   task automatic checkOutput();
      expect_t e;
      string   tag;
      e   = expQ.pop_front();
      tag = tagQ.pop_front();
      checkCount++;
      if (({ms_hour, ls_hour, ms_minute, ls_minute} !== e.disp) || (alarm_sound !== e.snd)) begin
         errorCount++;
         $display("[TB] FAIL %s edge=%0d display got '%s' want '%s', alarm_sound got %b want %b",
                  tag, e.edgeNo, {ms_hour, ls_hour, ms_minute, ls_minute}, e.disp, alarm_sound, e.snd);
      end
   endtask

   // Monitor: compare every queued expectation that belongs to the edges
   // already taken, away from the rising edge.
   initial begin : monitor
      forever begin
         @(negedge clock);
         while ((expQ.size() > 0) && (expQ[0].edgeNo <= edgeCount)) checkOutput();
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin : stimulus
      int t;
      reset        = 1'b1;
      fast_watch   = 1'b0;
      alarm_button = 1'b0;
      time_button  = 1'b0;
      key          = 4'd10;
      modelReset();
      #6;
      pushExpect();
      #4;
      reset = 1'b0;

      fast_watch = 1'b1;
      phase = "setTime";
      enterTime(11 * 60 + 23, 3);
      pulseTime();
      applyStimulus(3);

      phase = "setAlarm";
      enterTime(11 * 60 + 30, 3);
      pulseAlarm();
      phase = "ringWait";
      applyStimulus(7 * CPS);

      phase = "silence";
      pulseAlarm();
      applyStimulus(300);

      phase = "dayWrap";
      enterTime(23 * 60 + 59, 2);
      pulseTime();
      applyStimulus(CPS + 5);

      phase = "badTime";
      pressKey(2, 3); pressKey(5, 3); pressKey(0, 3); pressKey(0, 3);
      pulseTime();
      applyStimulus(5);

      phase = "timeout";
      pressKey(7, 2);
      applyStimulus(TMO * CPS + 4);

      phase = "longHold";
      pressKey(4, 10);
      applyStimulus(3);
      pulseTime();
      applyStimulus(3);

      phase = "slowRing";
      enterTime((mTime + 2) % 1440, 2);
      pulseAlarm();
      applyStimulus(3 * CPS);
      fast_watch = 1'b0;
      applyStimulus(61 * CPS);
      fast_watch = 1'b1;
      pulseAlarm();
      applyStimulus(10);

      phase = "random";
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 6))
            0, 1: pressKey($urandom_range(0, 9), $urandom_range(1, 12));
            2: pulseTime();
            3: pulseAlarm();
            4: begin
               fast_watch = ($urandom_range(0, 3) != 0);
               applyStimulus($urandom_range(1, 400));
               fast_watch = 1'b1;
            end
            5: begin
               time_button  = 1'b1;
               alarm_button = 1'b1;
               applyStimulus(1);
               time_button  = 1'b0;
               alarm_button = 1'b0;
            end
            default: begin
               t = (mTime + 1 + $urandom_range(0, 2)) % 1440;
               enterTime(t, $urandom_range(1, 4));
               if ($urandom_range(0, 1) == 1) pulseAlarm();
               else pulseTime();
            end
         endcase
         applyStimulus($urandom_range(0, 3));
      end

      phase = "midReset";
      pressKey(5, 2);
      pressKey(1, 2);
      pulseReset();
      applyStimulus(5);

      applyStimulus(2);
      @(negedge clock);
      #1;
      checkCount++;
      if (expQ.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
